// File: rtl/pkmc_wbm_pkg.sv
// Shared definitions for the pkmc Wishbone master block: FSM state encoding,
// word stride, command length width and the default bus-stall timeout.
package pkmc_wbm_pkg;

    // Byte distance between consecutive word beats.
    localparam int unsigned WORD_STRIDE = 4;

    // Width of the command word-count field.
    localparam int unsigned LEN_WIDTH = 8;

    // Default number of stalled strobe cycles before a beat is aborted.
    localparam int unsigned TIMEOUT_DEFAULT = 256;

    // Transfer FSM states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StBus     = 3'd2,
        StDeliver = 3'd3,
        StFinish  = 3'd4
    } wbm_state_e;

    // Address of the next word beat; wraps modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'(WORD_STRIDE);
    endfunction

endpackage

// File: rtl/pkmc_wbm_timeout.sv
// Bus-stall watchdog for the pkmc Wishbone master. Counts cycles where the
// strobe is high and the slave has answered with neither ack nor err, and
// flags expiry on the TIMEOUT-th such cycle. Only instantiated when the
// PKMC_WBM_TIMEOUT_EN macro is defined.
module pkmc_wbm_timeout
    import pkmc_wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q;
    logic            stall;

    // A cycle counts as stalled only while the beat is outstanding.
    always_comb begin
        stall  = stb & ~ack & ~err;
        expire = stall & (cnt_q == CntW'(TIMEOUT - 1));
    end

    // Stall counter: restarts whenever the beat resolves, the strobe drops,
    // or the watchdog fires (so it never wraps past TIMEOUT-1).
    always_ff @(posedge clk) begin
        if (rst || !stall || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pkmc_wbmaster_block.sv
// pkmc Wishbone classic initiator. Accepts a command (direction, start
// address, word count), then runs one single-word Wishbone beat per word:
// write data is pulled from the wr_* stream before each beat, read data is
// pushed onto the rd_* stream after each beat. cyc stays asserted across the
// whole burst. A bus error (or ack+err together) aborts the burst and the
// completion pulse carries error=1.
// Optional feature: define PKMC_WBM_TIMEOUT_EN to abort a beat after TIMEOUT
// stalled strobe cycles, exactly as if the slave had signalled an error.
module pkmc_wbmaster_block
    import pkmc_wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    // Command handshake
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    // Write-data stream
    input  logic [31:0]          wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    // Read-data stream
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    // Completion
    output logic                 done,
    output logic                 error,
    // Wishbone classic initiator
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [3:0]           wb_sel_o,
    output logic [31:0]          wb_dat_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i
);

    wbm_state_e           state_q, state_d;
    logic [31:0]          addr_q;
    logic [31:0]          wdat_q;
    logic [31:0]          rdat_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 dir_q;
    logic                 cyc_q;
    logic                 stb_q;
    logic                 err_q;

    logic                 cmd_fire;
    logic                 beat_ack;
    logic                 beat_err;
    logic                 last_beat;
    logic                 expire;

`ifdef PKMC_WBM_TIMEOUT_EN
    pkmc_wbm_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .stb    (stb_q),
        .ack    (wb_ack_i),
        .err    (wb_err_i),
        .expire (expire)
    );
`else
    // Without the watchdog a beat waits for the slave forever.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
`endif

    // Beat resolution: responses only count while our strobe is up, and an
    // error (or watchdog expiry) always beats a simultaneous ack.
    always_comb begin
        cmd_fire  = cmd_valid & cmd_ready;
        beat_err  = stb_q & (wb_err_i | expire);
        beat_ack  = stb_q & wb_ack_i & ~beat_err;
        last_beat = (len_q == LEN_WIDTH'(1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (cmd_len == '0) begin
                        state_d = StFinish;
                    end else if (cmd_write) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StBus;
                    end
                end
            end
            StFetch: begin
                if (wr_valid) begin
                    state_d = StBus;
                end
            end
            StBus: begin
                if (beat_err) begin
                    state_d = StFinish;
                end else if (beat_ack) begin
                    if (!dir_q) begin
                        state_d = StDeliver;
                    end else if (last_beat) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StDeliver: begin
                // len_q was already decremented by the ack of this beat.
                if (rd_ready) begin
                    state_d = (len_q == '0) ? StFinish : StBus;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Command context: latched on accept, advanced on every acked beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                dir_q  <= cmd_write;
                err_q  <= 1'b0;
            end else if (state_q == StBus) begin
                if (beat_err) begin
                    err_q <= 1'b1;
                end else if (beat_ack) begin
                    addr_q <= next_word_addr(addr_q);
                    len_q  <= len_q - 1'b1;
                end
            end
        end
    end

    // Bus control: stb rises the cycle after entering BUS and drops on the
    // edge that samples the response, so ack never reaches stb combinationally.
    // cyc spans the whole burst and only drops on the final ack or an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
        end else if (state_q == StBus) begin
            if (!stb_q) begin
                cyc_q <= 1'b1;
                stb_q <= 1'b1;
            end else if (beat_err) begin
                cyc_q <= 1'b0;
                stb_q <= 1'b0;
            end else if (beat_ack) begin
                stb_q <= 1'b0;
                if (last_beat) begin
                    cyc_q <= 1'b0;
                end
            end
        end
    end

    // Data registers: write word captured from the stream, read word from the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdat_q <= '0;
            rdat_q <= '0;
        end else begin
            if ((state_q == StFetch) && wr_valid) begin
                wdat_q <= wr_data;
            end
            if ((state_q == StBus) && beat_ack && !dir_q) begin
                rdat_q <= wb_dat_i;
            end
        end
    end

    // FSM and bus outputs.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state_q)
            StIdle:    cmd_ready = ~rst;
            StFetch:   wr_ready  = 1'b1;
            StDeliver: rd_valid  = 1'b1;
            StFinish: begin
                done  = 1'b1;
                error = err_q;
            end
            default: ;
        endcase
        wb_cyc_o = cyc_q;
        wb_stb_o = stb_q;
        wb_we_o  = cyc_q & dir_q;
        wb_sel_o = cyc_q ? 4'hF : 4'h0;
        wb_adr_o = addr_q;
        wb_dat_o = wdat_q;
        rd_data  = rdat_q;
    end

endmodule

// File: tb/tb_pkmc_wbmaster_block.sv
// Self-checking bench for pkmc_wbmaster_block. A Wishbone slave with its own
// memory answers the bus; an independent word-level model (start address,
// count, stride 4, memory contents) predicts beat addresses, write data, read
// data and the completion status of every command.
module tb_pkmc_wbmaster_block;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic        done, error;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    always #5 clk = ~clk;

    pkmc_wbmaster_block #(
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .done      (done),
        .error     (error),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Slave memory (environment) and model memory (prediction).
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] bg_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : bg_word(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : bg_word(a);
    endfunction

    logic [31:0] wq[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_dat[$];
    logic [31:0] got_rd[$];
    int          res_stb_cycles, res_stb_bad, res_stable_bad;
    bit          res_finished;

    // Runs one command to completion (or until stb_limit strobe cycles when the
    // slave never answers) and checks it against the word-level model.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input int mode, input int err_beat, input int rd_stall,
                           input int max_delay, input int stb_limit, input bit exp_fin);
        int cycles, beat_idx, wait_cnt, delay, stall_cnt, acc_cycle, done_cycle, widx;
        int n_attempt, n_ok, cyc_rises, done_cnt, wr_after_err, attr_bad;
        bit acc_pend, prev_cyc, beat_open, err_chk, err_seen, done_err;
        logic [31:0] held_rd;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_rd[$];

        // mode 0: all acked, mode 1: error on beat err_beat, mode 2: never answers
        n_attempt = (len == 0) ? 0 : (mode == 0) ? int'(len) : (mode == 1) ? err_beat + 1 : 1;
        n_ok      = (len == 0) ? 0 : (mode == 0) ? int'(len) : (mode == 1) ? err_beat : 0;
        for (int i = 0; i < n_attempt; i++) exp_addr.push_back(addr + 32'(i) * 32'd4);
        for (int i = 0; i < n_ok; i++) begin
            if (wr) model_mem[addr + 32'(i) * 32'd4] = wq[i];
            else    exp_rd.push_back(model_read(addr + 32'(i) * 32'd4));
        end

        cycles = 0; beat_idx = 0; wait_cnt = 0; delay = 0; stall_cnt = 0; widx = 0;
        acc_cycle = 0; done_cycle = 0; cyc_rises = 0; done_cnt = 0; wr_after_err = 0;
        attr_bad = 0; acc_pend = 0; prev_cyc = 0; beat_open = 0; err_chk = 0;
        err_seen = 0; done_err = 0; held_rd = '0;
        res_stb_cycles = 0; res_stb_bad = 0; res_stable_bad = 0; res_finished = 0;
        log_addr.delete(); log_dat.delete(); got_rd.delete();

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        while (!res_finished && cycles < 3000) begin
            if (acc_pend) begin
                cmd_valid = 1'b0;
                acc_pend  = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                acc_pend  = 1'b1;
                acc_cycle = cycles;
            end
            if (wb_cyc_o && !prev_cyc) cyc_rises++;
            prev_cyc = wb_cyc_o;
            if (err_chk) begin
                check("cyc_drop_after_err", 32'(wb_cyc_o), 32'(0));
                err_chk = 0;
            end
            if (err_seen && wr_ready) wr_after_err++;
            // write-data producer with random gaps
            wr_valid = 1'b0;
            if (wr_ready && widx < wq.size()) begin
                wr_valid = ($urandom_range(0, 2) != 0);
                wr_data  = wq[widx];
                if (wr_valid) widx++;
            end
            // read-data consumer, holding off for rd_stall cycles per word
            rd_ready = 1'b0;
            if (rd_valid) begin
                if (wb_stb_o) res_stb_bad++;
                if (stall_cnt == 0) held_rd = rd_data;
                else if (rd_data !== held_rd) res_stable_bad++;
                if (stall_cnt >= rd_stall) begin
                    rd_ready = 1'b1;
                    got_rd.push_back(rd_data);
                    stall_cnt = 0;
                end else begin
                    stall_cnt++;
                end
            end
            // Wishbone slave
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
            if (wb_stb_o) begin
                res_stb_cycles++;
                if (!beat_open) begin
                    beat_open = 1; wait_cnt = 0; delay = $urandom_range(0, max_delay);
                    log_addr.push_back(wb_adr_o);
                    log_dat.push_back(wb_dat_o);
                    if (wb_we_o !== wr || wb_sel_o !== 4'hF || wb_cyc_o !== 1'b1) attr_bad++;
                end
                if (mode != 2 && wait_cnt >= delay) begin
                    if (mode == 1 && beat_idx == err_beat) begin
                        wb_err_i = 1'b1; wb_ack_i = 1'($urandom_range(0, 1));
                        err_seen = 1; err_chk = 1;
                    end else begin
                        wb_ack_i = 1'b1;
                        if (wb_we_o) slave_mem[wb_adr_o] = wb_dat_o;
                        else         wb_dat_i = slave_read(wb_adr_o);
                    end
                    beat_open = 0;
                    beat_idx++;
                end else begin
                    wait_cnt++;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                // stray responses while stb is low must be ignored
                wb_ack_i = 1'b1; wb_err_i = 1'($urandom_range(0, 1));
            end
            if (done) begin
                done_cnt++; done_err = error; done_cycle = cycles; res_finished = 1;
            end
            if (mode == 2 && res_stb_cycles >= stb_limit) break;
            if (!res_finished) begin
                @(negedge clk);
                cycles++;
            end
        end

        check("cmd_finished", 32'(res_finished), 32'(exp_fin));
        if (res_finished) begin
            check("done_count", 32'(done_cnt), 32'(1));
            check("error_flag", 32'(done_err), 32'(mode != 0));
            check("beat_count", 32'(log_addr.size()), 32'(n_attempt));
            for (int i = 0; i < n_attempt && i < log_addr.size(); i++)
                check("beat_addr", log_addr[i], exp_addr[i]);
            if (wr) begin
                for (int i = 0; i < n_ok && i < log_dat.size(); i++)
                    check("beat_wdata", log_dat[i], wq[i]);
            end else begin
                check("rd_count", 32'(got_rd.size()), 32'(n_ok));
                for (int i = 0; i < n_ok && i < got_rd.size(); i++)
                    check("rd_data", got_rd[i], exp_rd[i]);
            end
            check("beat_attr", 32'(attr_bad), 32'(0));
            check("cyc_rises", 32'(cyc_rises), 32'(len != 0));
            if (len == 0) check("len0_done_latency", 32'(done_cycle - acc_cycle), 32'(1));
            if (mode == 1) check("no_wr_ready_after_err", 32'(wr_after_err), 32'(0));
            @(negedge clk);
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
            check("done_one_cycle", 32'(done), 32'(0));
            check("idle_ready", 32'(cmd_ready), 32'(1));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        logic [7:0]  l;
        logic [31:0] a;
        int          m, eb;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; wb_dat_i = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_bus_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'(0));
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat_o", wb_dat_o, 32'h0);
        check("rst_streams", 32'({wr_ready, rd_valid, done, error}), 32'(0));
        check("rst_rd_data", rd_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(cmd_ready), 32'(1));

        // three-beat write, slave acks in the first strobe cycle
        wq = '{32'hA, 32'hB, 32'hC};
        run_cmd(1'b1, 32'h2000_0000, 8'd3, 0, 0, 0, 0, 0, 1'b1);
        check("mem_2000_0008", slave_read(32'h2000_0008), 32'hC);

        // read with a consumer that holds off for 5 cycles per word
        slave_mem[32'h10] = 32'h1111;
        model_mem[32'h10] = 32'h1111;
        run_cmd(1'b0, 32'h0000_0010, 8'd2, 0, 0, 5, 1, 0, 1'b1);
        check("stall_rd_stable", 32'(res_stable_bad), 32'(0));
        check("stall_stb_low", 32'(res_stb_bad), 32'(0));
        if (got_rd.size() > 0) check("first_rd_1111", got_rd[0], 32'h1111);

        // address wraps from the top of the space
        run_cmd(1'b0, 32'hFFFF_FFFC, 8'd2, 0, 0, 1, 2, 0, 1'b1);

        // write whose first beat is errored
        wq = '{32'h1, 32'h2, 32'h3};
        run_cmd(1'b1, 32'h5000_0000, 8'd3, 1, 0, 0, 1, 0, 1'b1);

        // zero-length command
        wq.delete();
        run_cmd(1'b1, 32'h6000_0000, 8'd0, 0, 0, 0, 0, 0, 1'b1);

        // randomized commands
        for (int t = 0; t < 10; t++) begin
            w  = 1'($urandom_range(0, 1));
            l  = 8'($urandom_range(0, 5));
            a  = (t == 3) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            m  = (l != 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
            eb = (m == 1) ? int'($urandom_range(0, int'(l) - 1)) : 0;
            wq.delete();
            for (int i = 0; i < int'(l); i++) wq.push_back($urandom);
            run_cmd(w, a, l, m, eb, int'($urandom_range(0, 2)), 2, 0, 1'b1);
        end

        // slave that never answers
`ifdef PKMC_WBM_TIMEOUT_EN
        run_cmd(1'b0, 32'h3000_0000, 8'd2, 2, 0, 0, 0, 2000, 1'b1);
        check("timeout_stall_cycles", 32'(res_stb_cycles), 32'(TO));
        run_cmd(1'b0, 32'h4000_0000, 8'd1, 2, 0, 0, 0, 3, 1'b0);
`else
        run_cmd(1'b0, 32'h3000_0000, 8'd2, 2, 0, 0, 0, 1000, 1'b0);
        check("stb_cycles_no_timeout", 32'(res_stb_cycles), 32'(1000));
        check("stb_still_high", 32'(wb_stb_o), 32'(1));
`endif

        // reset in the middle of a bus beat
        check("cyc_before_rst", 32'(wb_cyc_o), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drops_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'(0));
        check("rst_no_done", 32'({done, error}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_rst", 32'(cmd_ready), 32'(1));
        check("no_done_after_rst", 32'(done), 32'(0));

        // normal operation resumes after reset
        run_cmd(1'b0, 32'h2000_0004, 8'd2, 0, 0, 0, 1, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pkmc_wbmaster_block.md
PKMC_WBMASTER_BLOCK -- requirements
Module: pkmc_wbmaster_block

Interface
REQ-001 Parameter TIMEOUT, default 256, bus-stall cycles before abort (valid only with PKMC_WBM_TIMEOUT_EN).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in 32, cmd_len in 8: command handshake; cmd_len is the word count.
REQ-006 wr_data in 32, wr_valid in 1, wr_ready out 1: write-data stream.
REQ-007 rd_data out 32, rd_valid out 1, rd_ready in 1: read-data stream.
REQ-008 done out 1, error out 1: one-cycle completion pulse; error qualifies done.
REQ-009 wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out 32; wb_sel_o out 4; wb_dat_o out 32; wb_dat_i in 32; wb_ack_i, wb_err_i in 1: Wishbone classic initiator.

Function
REQ-010 States SHALL be IDLE, FETCH, BUS, DELIVER, FINISH.
REQ-011 IDLE: cmd_ready=1; a command is accepted on cmd_valid&cmd_ready; addr, len and direction SHALL be latched.
REQ-012 cmd_len=0 SHALL go to FINISH with no bus activity; done pulses 1 cycle later.
REQ-013 Write: FETCH asserts wr_ready; when wr_valid, data is latched into wb_dat_o and the state goes to BUS. Read: go directly to BUS.
REQ-014 BUS: wb_cyc_o=wb_stb_o=1, wb_sel_o=4'hF, wb_we_o=direction; wb_cyc_o SHALL stay high from the first beat through the last ack.
REQ-015 On wb_ack_i: wb_stb_o drops next cycle; the address increments by 4 (modulo 2^32); the remaining count decrements.
REQ-016 Read ack: rd_data<=wb_dat_i; go to DELIVER with rd_valid=1 until rd_ready; then go to BUS, or to FINISH if the count is zero.
REQ-017 Write ack: go to FETCH, or to FINISH if the count is zero.
REQ-018 On wb_err_i, or on ack and err in the same cycle, err SHALL win: no data is delivered, cyc/stb drop next cycle, and FINISH raises error.
REQ-019 FINISH: done=1 for exactly one cycle, then go to IDLE; cmd_ready=0 in FINISH.
REQ-020 ack/err SHALL be ignored while wb_stb_o=0.
REQ-021 Each beat's bus latency SHALL be 1 cycle from entering BUS to stb high, with no combinational path from wb_ack_i to wb_stb_o.

Reset
REQ-022 On rst, the state SHALL be IDLE and all outputs 0, except cmd_ready=1 after the reset release cycle.
REQ-023 Reset mid-transfer SHALL drop wb_cyc_o/wb_stb_o on the same edge; no done/error is generated.

Configuration
REQ-024 With PKMC_WBM_TIMEOUT_EN defined, a counter SHALL count cycles with stb=1 and no ack/err; when it reaches TIMEOUT, the beat is treated as wb_err_i (REQ-018).
REQ-025 Without PKMC_WBM_TIMEOUT_EN, the block SHALL wait indefinitely for ack/err, and the counter logic is absent.

Structure
REQ-026 Package pkmc_wbm_pkg SHALL hold the state encoding, WORD_STRIDE=4, LEN_WIDTH=8, and the default TIMEOUT.
REQ-027 Sub-module pkmc_wbm_timeout SHALL hold the stall counter (clear on ack/err/stb low; expire flag); it is instantiated only under PKMC_WBM_TIMEOUT_EN.

Verification
REQ-028 Write cmd addr 0x2000_0000, len 3, data 0xA,0xB,0xC, slave ack in 1 cycle -> three beats at 0x2000_0000/04/08, we=1, cyc continuous, done=1, error=0.
REQ-029 Read cmd addr 0x0000_0010, len 2, rd_ready low 5 cycles -> rd_valid holds 0x1111 stable, stb stays low until accepted, second beat at 0x14.
REQ-030 Read addr 0xFFFF_FFFC, len 2 -> second beat at 0x0000_0000.
REQ-031 Write to 0x5000_0000 with slave err on beat 1 -> cyc low next cycle, done=1 with error=1, no further wr_ready.
REQ-032 PKMC_WBM_TIMEOUT_EN, TIMEOUT=16, slave never acks -> abort after 16 stalled cycles, error=1; without macro, stb still high after 1000 cycles.
REQ-033 Cmd len 0 -> no cyc; done 1 cycle after acceptance. Rst during BUS -> cyc=0 on that edge, cmd_ready=1 after release.
